// File: rtl/vpu_pkg.sv
// vpu_pkg: shared types and constants for the VPU instruction sequencer.
package vpu_pkg;

    // Sequencer states; one instruction is in flight at a time.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        READ   = 3'd2,
        WRITE  = 3'd3,
        RETIRE = 3'd4,
        ABORT  = 3'd5
    } vpu_issue_state_e;

    // 32-bit VPU instruction word, shared with vpu_top.
    typedef struct packed {
        logic [7:0] rsvd;
        logic [4:0] const_addr;
        logic [4:0] c_addr;
        logic [4:0] b_addr;
        logic [4:0] a_addr;
        logic [3:0] opcode;
    } inst_t;

    localparam logic [3:0] OPC_UNARY    = 4'd2;
    localparam int         RD_CYC_UNARY = 4;
    localparam int         RD_CYC_BIN   = 8;

    // Number of read-phase cycles the VPU needs for a given opcode.
    function automatic logic [3:0] rd_cycles(input logic [3:0] opcode);
        return (opcode == OPC_UNARY) ? 4'(RD_CYC_UNARY) : 4'(RD_CYC_BIN);
    endfunction

endpackage

// File: rtl/vpu_inst_fifo.sv
// vpu_inst_fifo: synchronous FIFO with registered full/empty flags. A write while
// full is accepted when a read happens in the same cycle.
module vpu_inst_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             do_wr, do_rd;

    assign do_rd = rd_en & ~empty_q;
    assign do_wr = wr_en & (~full_q | do_rd);
    assign rdata = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

    // Pointer and occupancy update; flags are derived from the next count so they are registered.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_wr, do_rd})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == CNT_FULL);
        empty_d = (count_d == '0);
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/vpu_issue_ctrl.sv
// vpu_issue_ctrl: buffers VPU instructions and sequences them one at a time through the
// VPU handshake (start pulse, read phase, arbitrated write phase), retiring on done and
// aborting via a watchdog if the VPU hangs.
//
// Handshake: an instruction is pushed on a cycle where in_valid && in_ready; in_ready
// depends only on registered FIFO state, and in_valid may not be withdrawn by the
// producer until accepted. The write port is requested with wr_req; vpu_wr_en is
// wr_req && wr_gnt. vpu_done is a single-cycle pulse accepted only in WRITE.
module vpu_issue_ctrl
    import vpu_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int WDOG_CYC   = 64,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [31:0]      in_inst,
    output logic             in_ready,
    output logic [31:0]      vpu_inst,
    output logic             vpu_mem_rdy,
    output logic             vpu_rd_en,
    output logic             vpu_wr_en,
    output logic             vpu_rst,
    input  logic             vpu_done,
    output logic             wr_req,
    input  logic             wr_gnt,
    output logic             busy,
    output logic             err_timeout,
    output logic [CNT_W-1:0] retired_cnt,
    output logic [CNT_W-1:0] abort_cnt
);

    localparam int              WD_W    = $clog2(WDOG_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDOG_CYC - 1);

    vpu_issue_state_e state_q, state_d;
    inst_t            inst_q, inst_d;
    logic             mem_rdy_q, mem_rdy_d;
    logic             rd_en_q, rd_en_d;
    logic             wr_req_q, wr_req_d;
    logic             vpu_rst_q, vpu_rst_d;
    logic [3:0]       rd_cnt_q, rd_cnt_d;
    logic [WD_W-1:0]  wdog_q, wdog_d;
    logic             abort_cyc_q, abort_cyc_d;
    logic [CNT_W-1:0] retired_cnt_q, retired_cnt_d;
    logic [CNT_W-1:0] abort_cnt_q, abort_cnt_d;
    logic             err_q, err_d;

    logic             fifo_push, fifo_pop;
    logic [31:0]      fifo_rdata;
    logic             fifo_full, fifo_empty;
    logic             wdog_expired;
    logic [3:0]       rd_last;

    assign fifo_push = in_valid & ~fifo_full;

    vpu_inst_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (fifo_push),
        .wdata (in_inst),
        .rd_en (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign in_ready    = ~fifo_full;
    assign vpu_inst    = inst_q;
    assign vpu_mem_rdy = mem_rdy_q;
    assign vpu_rd_en   = rd_en_q;
    assign wr_req      = wr_req_q;
    assign vpu_wr_en   = wr_req_q & wr_gnt;
    assign vpu_rst     = vpu_rst_q;
    assign busy        = (state_q != IDLE) | ~fifo_empty;
    assign err_timeout = err_q;
    assign retired_cnt = retired_cnt_q;
    assign abort_cnt   = abort_cnt_q;

    // Next-state logic for the sequencer, watchdog and counters; outputs decode the next state.
    always_comb begin
        state_d       = state_q;
        inst_d        = inst_q;
        rd_cnt_d      = rd_cnt_q;
        wdog_d        = wdog_q;
        abort_cyc_d   = abort_cyc_q;
        retired_cnt_d = retired_cnt_q;
        abort_cnt_d   = abort_cnt_q;
        err_d         = err_q;
        fifo_pop      = 1'b0;
        wdog_expired  = (wdog_q == WD_LAST);
        rd_last       = rd_cycles(inst_q.opcode) - 4'd1;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    inst_d   = inst_t'(fifo_rdata);
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                rd_cnt_d = '0;
                wdog_d   = '0;
                state_d  = READ;
            end
            READ: begin
                wdog_d = wdog_q + WD_W'(1);
                if (wdog_expired) begin
                    state_d = ABORT;
                end else if (rd_cnt_q == rd_last) begin
                    state_d = WRITE;
                end else begin
                    rd_cnt_d = rd_cnt_q + 4'd1;
                end
            end
            WRITE: begin
                wdog_d = wdog_q + WD_W'(1);
                // A done arriving on the expiry cycle still retires the instruction.
                if (vpu_done) begin
                    state_d = RETIRE;
                end else if (wdog_expired) begin
                    state_d = ABORT;
                end
            end
            RETIRE: begin
                retired_cnt_d = retired_cnt_q + CNT_W'(1);
                state_d       = IDLE;
            end
            ABORT: begin
                if (abort_cyc_q) begin
                    abort_cyc_d = 1'b0;
                    state_d     = IDLE;
                end else begin
                    abort_cyc_d = 1'b1;
                    abort_cnt_d = abort_cnt_q + CNT_W'(1);
                    err_d       = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        mem_rdy_d = (state_d == ISSUE);
        rd_en_d   = (state_d == READ) || (state_d == WRITE);
        wr_req_d  = (state_d == WRITE);
        vpu_rst_d = (state_d == ABORT);
    end

    // Sequencer registers; vpu_rst powers up high so the VPU sees reset on the first edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            inst_q        <= '0;
            mem_rdy_q     <= 1'b0;
            rd_en_q       <= 1'b0;
            wr_req_q      <= 1'b0;
            vpu_rst_q     <= 1'b1;
            rd_cnt_q      <= '0;
            wdog_q        <= '0;
            abort_cyc_q   <= 1'b0;
            retired_cnt_q <= '0;
            abort_cnt_q   <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            inst_q        <= inst_d;
            mem_rdy_q     <= mem_rdy_d;
            rd_en_q       <= rd_en_d;
            wr_req_q      <= wr_req_d;
            vpu_rst_q     <= vpu_rst_d;
            rd_cnt_q      <= rd_cnt_d;
            wdog_q        <= wdog_d;
            abort_cyc_q   <= abort_cyc_d;
            retired_cnt_q <= retired_cnt_d;
            abort_cnt_q   <= abort_cnt_d;
            err_q         <= err_d;
        end
    end

    // A done pulse is only meaningful while the write phase is active.
    done_only_in_write: assert property (@(posedge clk) disable iff (!rst_n)
        vpu_done |-> (state_q == WRITE))
        else $error("vpu_done seen outside WRITE");

endmodule

// File: tb/tb_vpu_issue_ctrl.sv
// tb_vpu_issue_ctrl: directed bench for the VPU instruction sequencer.
module tb_vpu_issue_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_inst;
    logic        in_ready;
    logic [31:0] vpu_inst;
    logic        vpu_mem_rdy;
    logic        vpu_rd_en;
    logic        vpu_wr_en;
    logic        vpu_rst;
    logic        vpu_done;
    logic        wr_req;
    logic        wr_gnt;
    logic        busy;
    logic        err_timeout;
    logic [15:0] retired_cnt;
    logic [15:0] abort_cnt;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_retired = 0;
    int          exp_abort   = 0;
    int          errs = 0;
    logic [31:0] cur_inst = '0;
    logic [31:0] p_inst [5];

    vpu_issue_ctrl #(
        .FIFO_DEPTH (4),
        .WDOG_CYC   (64),
        .CNT_W      (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_inst     (in_inst),
        .in_ready    (in_ready),
        .vpu_inst    (vpu_inst),
        .vpu_mem_rdy (vpu_mem_rdy),
        .vpu_rd_en   (vpu_rd_en),
        .vpu_wr_en   (vpu_wr_en),
        .vpu_rst     (vpu_rst),
        .vpu_done    (vpu_done),
        .wr_req      (wr_req),
        .wr_gnt      (wr_gnt),
        .busy        (busy),
        .err_timeout (err_timeout),
        .retired_cnt (retired_cnt),
        .abort_cnt   (abort_cnt)
    );

    // Clock and global time limit.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed still running, expected finished");
        $fatal(1, "bench time limit reached");
    end

    // Comparison helper.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_inst(input logic [3:0] op, input logic [4:0] a,
                                            input logic [4:0] b, input logic [4:0] c);
        return {8'h00, 5'd0, c, b, a, op};
    endfunction

    function automatic int exp_rd(input logic [31:0] inst);
        return (inst[3:0] == 4'd2) ? 4 : 8;
    endfunction

    // Drivers: inputs change 1 time unit after the rising edge, outputs are sampled there too.
    task automatic push(input logic [31:0] inst);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_inst  = inst;
        while (!in_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 200) check("push_timeout", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_issue(input logic [31:0] inst);
        int n;
        n = 0;
        while (!vpu_mem_rdy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("issue_pulse", 32'(vpu_mem_rdy), 32'd1);
        check("issue_inst", vpu_inst, inst);
        cur_inst = inst;
        errs = 0;
    endtask

    task automatic read_phase(input int rd_exp);
        int n;
        n = 0;
        @(posedge clk); #1;
        while (!wr_req && n < 20) begin
            if (!vpu_rd_en || vpu_mem_rdy || vpu_wr_en || vpu_inst !== cur_inst) errs++;
            n++;
            @(posedge clk); #1;
        end
        check("read_cycles", 32'(n), 32'(rd_exp));
    endtask

    task automatic write_phase(input int gnt_low, input int wr_cyc);
        int n;
        n = 0;
        while (!wr_req && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("write_entry", 32'(wr_req), 32'd1);
        for (int k = 1; k <= wr_cyc; k++) begin
            if (k > 1) begin
                @(posedge clk); #1;
            end
            wr_gnt = (k > gnt_low);
            #1;
            if (vpu_wr_en !== wr_gnt || !wr_req || !vpu_rd_en) errs++;
            if (vpu_mem_rdy || vpu_rst || vpu_inst !== cur_inst) errs++;
        end
        vpu_done = 1'b1;
        @(posedge clk); #1;
        vpu_done = 1'b0;
    endtask

    task automatic retire_phase();
        check("retire_outs", {28'h0, wr_req, vpu_rd_en, vpu_wr_en, vpu_rst}, 32'h0);
        check("retire_inst", vpu_inst, cur_inst);
        exp_retired++;
        @(posedge clk); #1;
        check("retired_cnt", 32'(retired_cnt), 32'(exp_retired));
        check("abort_cnt", 32'(abort_cnt), 32'(exp_abort));
        check("issue_gap", 32'(vpu_mem_rdy), 32'd0);
        check("op_sequence", 32'(errs), 32'd0);
    endtask

    task automatic run_op(input logic [31:0] inst, input int gnt_low, input int wr_cyc);
        wait_issue(inst);
        read_phase(exp_rd(inst));
        write_phase(gnt_low, wr_cyc);
        retire_phase();
    endtask

    // Directed sequence.
    initial begin
        int aerr;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_inst  = '0;
        vpu_done = 1'b0;
        wr_gnt   = 1'b1;
        p_inst[0] = mk_inst(4'd2, 5'd4, 5'd5, 5'd6);
        p_inst[1] = mk_inst(4'd5, 5'd7, 5'd8, 5'd9);
        p_inst[2] = mk_inst(4'd2, 5'd10, 5'd11, 5'd12);
        p_inst[3] = mk_inst(4'd0, 5'd13, 5'd14, 5'd15);
        p_inst[4] = mk_inst(4'd15, 5'd16, 5'd17, 5'd18);

        // Test 1: reset values, then a single instruction.
        repeat (3) @(posedge clk);
        #1;
        check("rst_inst", vpu_inst, 32'h0);
        check("rst_outs", {25'h0, vpu_mem_rdy, vpu_rd_en, vpu_wr_en, wr_req, busy, err_timeout, in_ready},
              32'h1);
        check("rst_vpu_rst", 32'(vpu_rst), 32'd1);
        check("rst_counts", {retired_cnt, abort_cnt}, 32'h0);
        rst_n = 1'b1;
        #1;
        check("rst_hold", 32'(vpu_rst), 32'd1);
        @(posedge clk); #1;
        check("rst_drop", 32'(vpu_rst), 32'd0);
        push(mk_inst(4'd1, 5'd1, 5'd2, 5'd3));
        run_op(mk_inst(4'd1, 5'd1, 5'd2, 5'd3), 0, 2);
        check("t1_busy", 32'(busy), 32'd0);

        // Test 2: fill the FIFO behind a stalled instruction.
        push(mk_inst(4'd1, 5'd30, 5'd29, 5'd28));
        wait_issue(mk_inst(4'd1, 5'd30, 5'd29, 5'd28));
        for (int i = 0; i < 4; i++) begin
            check("t2_ready_before", 32'(in_ready), 32'd1);
            push(p_inst[i]);
        end
        check("t2_full", 32'(in_ready), 32'd0);
        check("t2_busy", 32'(busy), 32'd1);
        fork
            push(p_inst[4]);
            begin
                write_phase(0, 3);
                retire_phase();
                for (int i = 0; i < 5; i++) run_op(p_inst[i], 0, 2);
            end
        join

        // Test 3: grant withheld for 20 write cycles.
        push(mk_inst(4'd3, 5'd1, 5'd1, 5'd1));
        run_op(mk_inst(4'd3, 5'd1, 5'd1, 5'd1), 20, 22);
        check("t3_no_err", 32'(err_timeout), 32'd0);

        // Test 4: done never arrives, watchdog aborts after 64 cycles.
        push(mk_inst(4'd1, 5'd2, 5'd2, 5'd2));
        push(mk_inst(4'd2, 5'd3, 5'd3, 5'd3));
        wait_issue(mk_inst(4'd1, 5'd2, 5'd2, 5'd2));
        aerr = 0;
        for (int i = 1; i <= 64; i++) begin
            @(posedge clk); #1;
            if (vpu_rst !== 1'b0 || vpu_rd_en !== 1'b1) aerr++;
        end
        check("t4_no_early_abort", 32'(aerr), 32'd0);
        @(posedge clk); #1;
        check("t4_abort_c1", {29'h0, vpu_rst, vpu_rd_en, wr_req}, 32'h4);
        @(posedge clk); #1;
        check("t4_abort_c2", 32'(vpu_rst), 32'd1);
        @(posedge clk); #1;
        exp_abort = 1;
        check("t4_rst_end", 32'(vpu_rst), 32'd0);
        check("t4_err", 32'(err_timeout), 32'd1);
        check("t4_abort_cnt", 32'(abort_cnt), 32'(exp_abort));
        check("t4_retired_cnt", 32'(retired_cnt), 32'(exp_retired));
        @(posedge clk); #1;
        check("t4_next_issue", 32'(vpu_mem_rdy), 32'd1);
        run_op(mk_inst(4'd2, 5'd3, 5'd3, 5'd3), 0, 2);

        // Test 6: done on the watchdog expiry cycle retires.
        push(mk_inst(4'd1, 5'd9, 5'd9, 5'd9));
        run_op(mk_inst(4'd1, 5'd9, 5'd9, 5'd9), 0, 56);
        check("t6_err_sticky", 32'(err_timeout), 32'd1);

        // Test 5: reset asserted mid-WRITE with an entry queued.
        push(mk_inst(4'd2, 5'd20, 5'd21, 5'd22));
        push(mk_inst(4'd3, 5'd23, 5'd24, 5'd25));
        wait_issue(mk_inst(4'd2, 5'd20, 5'd21, 5'd22));
        read_phase(4);
        check("t5_in_write", 32'(wr_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("t5_inst", vpu_inst, 32'h0);
        check("t5_outs", {25'h0, vpu_mem_rdy, vpu_rd_en, vpu_wr_en, wr_req, busy, err_timeout, in_ready},
              32'h1);
        check("t5_vpu_rst", 32'(vpu_rst), 32'd1);
        check("t5_counts", {retired_cnt, abort_cnt}, 32'h0);
        exp_retired = 0;
        exp_abort   = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        aerr = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (vpu_mem_rdy || busy || vpu_rd_en) aerr++;
        end
        check("t5_fifo_empty", 32'(aerr), 32'd0);
        push(mk_inst(4'd4, 5'd1, 5'd3, 5'd5));
        run_op(mk_inst(4'd4, 5'd1, 5'd3, 5'd5), 0, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
